ase_fifo_pacer: RTL and testbench

Downstream drain stage for the ASE simulation FIFO. Issues read enables to the FIFO against its registered `empty` flag and credits them against its one-cycle read latency. Captures returned words into a small circular buffer and presents them on a valid/ready output with a programmable minimum idle gap between transfers. Used to shape traffic leaving ASE buffers toward the AFU-facing channel models.

---
 rtl/ase_fifo_pkg.sv | 19 +
 rtl/ase_fifo_pacer_buf.sv | 56 +++++
 rtl/ase_fifo_pacer.sv | 101 ++++++++++
 tb/tb_ase_fifo_pacer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ase_fifo_pkg.sv
// Shared types and helpers for the ASE FIFO drain stage (ase_fifo_pacer).
package ase_fifo_pkg;

    localparam int unsigned PACER_STAT_W = 32;

    typedef logic [PACER_STAT_W-1:0] pacer_stat_t;

    // Width of the inter-transfer gap counter; never narrower than one bit.
    function automatic int unsigned pacer_gap_w(input int gap);
        int unsigned w;
        if (gap < 1) begin
            w = 1;
        end else begin
            w = $clog2(gap + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/ase_fifo_pacer_buf.sv
// Circular register buffer: push/pop with natural pointer wrap and occupancy.
module ase_fifo_pacer_buf #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0]      occ,
    output logic                  full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_ok;

    assign full    = (occ == OCC_W'(DEPTH));
    // A push into a full buffer is only legal when a pop frees the slot this cycle.
    assign wr_ok   = push && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ase_fifo_pacer.sv
// Credit-based FIFO drain with capture buffer and paced valid/ready output.
// Optional statistics counters are built when ASE_FIFO_PACER_STATS_EN is defined.
module ase_fifo_pacer
    import ase_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BUF_DEPTH  = 4,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_v,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  overrun_err,
    output pacer_stat_t           stat_stall_cnt,
    output pacer_stat_t           stat_empty_rd_cnt
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = OCC_W + 1;
    localparam int unsigned GAP_W = pacer_gap_w(int'(GAP_CYCLES));

    logic [OCC_W-1:0] occ;
    logic             full;
    logic             inflight;
    logic             push;
    logic             pop;
    logic [GAP_W-1:0] gap_cnt;

    // Outstanding read counts against buffer space until its return slot passes.
    assign fifo_rd_en = !rst && !fifo_empty
                        && ((SUM_W'(occ) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH));
    assign out_valid  = (occ != '0) && (gap_cnt == '0);
    assign pop        = out_valid && out_ready;
    assign push       = fifo_data_v && !rst;

    ase_fifo_pacer_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_data),
        .pop       (pop),
        .rd_data   (out_data),
        .occ       (occ),
        .full      (full)
    );

    // Credit, pacing gap and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight    <= 1'b0;
            gap_cnt     <= '0;
            overrun_err <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                gap_cnt <= GAP_W'(GAP_CYCLES);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            if (push && full && !pop) begin
                overrun_err <= 1'b1;
            end
        end
    end

`ifdef ASE_FIFO_PACER_STATS_EN
    pacer_stat_t stall_q;
    pacer_stat_t empty_rd_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q    <= '0;
            empty_rd_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + PACER_STAT_W'(1);
            end
            if (inflight && !fifo_data_v && (empty_rd_q != '1)) begin
                empty_rd_q <= empty_rd_q + PACER_STAT_W'(1);
            end
        end
    end

    assign stat_stall_cnt    = stall_q;
    assign stat_empty_rd_cnt = empty_rd_q;
`else
    assign stat_stall_cnt    = '0;
    assign stat_empty_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_ase_fifo_pacer.sv
// Directed bench for ase_fifo_pacer: drain, backpressure, stale empty, overrun, reset, gap.
module tb_ase_fifo_pacer;

    localparam int unsigned DW = 64;
`ifdef ASE_FIFO_PACER_STATS_EN
    localparam int STATS_ON = 1;
`else
    localparam int STATS_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          fifo_data_v;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          overrun_err;
    logic [31:0]   stat_stall_cnt;
    logic [31:0]   stat_empty_rd_cnt;

    logic          g_rst;
    logic          g_fifo_empty;
    logic          g_fifo_rd_en;
    logic [DW-1:0] g_fifo_data;
    logic          g_fifo_data_v;
    logic          g_out_valid;
    logic [DW-1:0] g_out_data;
    logic          g_out_ready;
    logic          g_overrun_err;
    logic [31:0]   g_stat_stall_cnt;
    logic [31:0]   g_stat_empty_rd_cnt;

    ase_fifo_pacer #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data), .fifo_data_v(fifo_data_v), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .overrun_err(overrun_err),
        .stat_stall_cnt(stat_stall_cnt), .stat_empty_rd_cnt(stat_empty_rd_cnt)
    );

    ase_fifo_pacer #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .GAP_CYCLES(3)) dut_gap (
        .clk(clk), .rst(g_rst), .fifo_empty(g_fifo_empty), .fifo_rd_en(g_fifo_rd_en),
        .fifo_data(g_fifo_data), .fifo_data_v(g_fifo_data_v), .out_valid(g_out_valid),
        .out_data(g_out_data), .out_ready(g_out_ready), .overrun_err(g_overrun_err),
        .stat_stall_cnt(g_stat_stall_cnt), .stat_empty_rd_cnt(g_stat_empty_rd_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] q[$];
    logic          prev_rd;
    bit            model_en;
    bit            stale_hold;
    int            reads;
    int            empty_reads;
    int            tr_cyc[$];
    logic [DW-1:0] tr_dat[$];
    int            g_cyc[$];
    logic [DW-1:0] g_dat[$];
    int            c0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records handshakes at the edge, advances one clock, then plays the FIFO model.
    task automatic cycle();
        logic rst_s;
        if (out_valid && out_ready) begin
            tr_cyc.push_back(cyc);
            tr_dat.push_back(out_data);
        end
        if (g_out_valid && g_out_ready) begin
            g_cyc.push_back(cyc);
            g_dat.push_back(g_out_data);
        end
        if (fifo_rd_en) reads++;
        prev_rd = fifo_rd_en;
        rst_s   = rst;
        @(posedge clk);
        cyc++;
        #1;
        if (model_en) begin
            fifo_data_v = 1'b0;
            if (rst_s) begin
                q.delete();
                fifo_empty = 1'b1;
            end else begin
                if (prev_rd) begin
                    if (q.size() > 0) begin
                        fifo_data   = q.pop_front();
                        fifo_data_v = 1'b1;
                    end else begin
                        empty_reads++;
                    end
                end
                fifo_empty = (q.size() == 0) && !stale_hold;
            end
        end
        #1;
    endtask

    function automatic logic [DW-1:0] tr_at(input int i);
        return (i < tr_dat.size()) ? tr_dat[i] : 'x;
    endfunction

    function automatic int trc_at(input int i);
        return (i < tr_cyc.size()) ? tr_cyc[i] : -1;
    endfunction

    initial begin
        rst = 1'b1; fifo_empty = 1'b1; fifo_data = '0; fifo_data_v = 1'b0; out_ready = 1'b0;
        g_rst = 1'b1; g_fifo_empty = 1'b1; g_fifo_data = '0; g_fifo_data_v = 1'b0; g_out_ready = 1'b1;
        model_en = 1'b1; stale_hold = 1'b0; reads = 0; empty_reads = 0; prev_rd = 1'b0;

        // Reset state
        cycle(); cycle();
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_overrun", 64'(overrun_err), 64'd0);
        chk("rst_stall", 64'(stat_stall_cnt), 64'd0);
        chk("rst_empty_rd", 64'(stat_empty_rd_cnt), 64'd0);
        rst = 1'b0; g_rst = 1'b0;
        cycle();

        // Drain three words back-to-back
        q.push_back(64'hA); q.push_back(64'hB); q.push_back(64'hC);
        out_ready = 1'b1;
        tr_cyc.delete(); tr_dat.delete();
        cycle();
        c0 = cyc;
        chk("drain_rd_en_first", 64'(fifo_rd_en), 64'd1);
        repeat (6) cycle();
        chk("drain_count", 64'(tr_dat.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("drain_data", tr_at(i), 64'hA + 64'(i));
            chk("drain_cycle", 64'(trc_at(i)), 64'(c0 + 2 + i));
        end

        // Backpressure: ten queued words, output stalled
        out_ready = 1'b0; reads = 0;
        tr_cyc.delete(); tr_dat.delete();
        for (int i = 0; i < 10; i++) q.push_back(64'h100 + 64'(i));
        repeat (6) cycle();
        chk("bp_hold_data_early", out_data, 64'h100);
        repeat (6) cycle();
        chk("bp_reads", 64'(reads), 64'd4);
        chk("bp_rd_en_low", 64'(fifo_rd_en), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data", out_data, 64'h100);
        chk("bp_overrun", 64'(overrun_err), 64'd0);
        chk("bp_stall_cnt", 64'(stat_stall_cnt), (STATS_ON != 0) ? 64'd9 : 64'd0);
        out_ready = 1'b1;
        repeat (20) cycle();
        chk("bp_drain_count", 64'(tr_dat.size()), 64'd10);
        for (int i = 0; i < 10; i++) chk("bp_drain_data", tr_at(i), 64'h100 + 64'(i));
        chk("bp_overrun_after", 64'(overrun_err), 64'd0);

        // Stale empty: one read returns nothing
        stale_hold = 1'b1; empty_reads = 0;
        cycle();
        chk("stale_rd_en", 64'(fifo_rd_en), 64'd1);
        stale_hold = 1'b0;
        cycle();
        chk("stale_rd_en_release", 64'(fifo_rd_en), 64'd0);
        cycle();
        chk("stale_no_write", 64'(out_valid), 64'd0);
        chk("stale_empty_rd_cnt", 64'(stat_empty_rd_cnt), (STATS_ON != 0) ? 64'd1 : 64'd0);
        cycle();
        chk("stale_no_write_late", 64'(out_valid), 64'd0);

        // Overrun: forced returns into a full, stalled buffer
        model_en = 1'b0; fifo_empty = 1'b1; out_ready = 1'b0;
        tr_cyc.delete(); tr_dat.delete();
        for (int i = 0; i < 5; i++) begin
            fifo_data = 64'h200 + 64'(i); fifo_data_v = 1'b1;
            cycle();
        end
        fifo_data_v = 1'b0;
        chk("ovr_flag", 64'(overrun_err), 64'd1);
        chk("ovr_out_valid", 64'(out_valid), 64'd1);
        chk("ovr_head", out_data, 64'h200);
        // Capture and transfer together while full: no drop
        out_ready = 1'b1; fifo_data = 64'h2AA; fifo_data_v = 1'b1;
        cycle();
        fifo_data_v = 1'b0;
        repeat (6) cycle();
        chk("ovr_drain_count", 64'(tr_dat.size()), 64'd5);
        for (int i = 0; i < 4; i++) chk("ovr_drain_data", tr_at(i), 64'h200 + 64'(i));
        chk("ovr_full_swap_data", tr_at(4), 64'h2AA);
        chk("ovr_sticky", 64'(overrun_err), 64'd1);

        // Reset mid-stream
        model_en = 1'b1; rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst2_overrun_clr", 64'(overrun_err), 64'd0);
        chk("rst2_stall_clr", 64'(stat_stall_cnt), 64'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) q.push_back(64'h300 + 64'(i));
        repeat (4) cycle();
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        chk("mid_head", out_data, 64'h300);
        chk("mid_inflight_ret", 64'(fifo_data_v), 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        tr_cyc.delete(); tr_dat.delete();
        q.push_back(64'h400); q.push_back(64'h401);
        out_ready = 1'b1;
        repeat (6) cycle();
        chk("mid_resume_count", 64'(tr_dat.size()), 64'd2);
        chk("mid_resume_d0", tr_at(0), 64'h400);
        chk("mid_resume_d1", tr_at(1), 64'h401);

        // Gap of three idle cycles between transfers
        g_cyc.delete(); g_dat.delete();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            g_fifo_data = 64'h50 + 64'(i); g_fifo_data_v = 1'b1;
            cycle();
        end
        g_fifo_data_v = 1'b0;
        repeat (16) cycle();
        chk("gap_count", 64'(g_dat.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("gap_data", (i < g_dat.size()) ? g_dat[i] : 'x, 64'h50 + 64'(i));
            chk("gap_cycle", 64'((i < g_cyc.size()) ? g_cyc[i] : -1), 64'(c0 + 1 + 4 * i));
        end
        chk("gap_rd_en", 64'(g_fifo_rd_en), 64'd0);
        chk("gap_overrun", 64'(g_overrun_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
